multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the MIPS-subset datapath: instruction fetch, decode, ALU, memory access and PC update.
- Drives the PC mux select, branch and jump controls, and the register-file and memory strobes.
- Waits on a shared memory ready handshake, with a watchdog timeout.
- Sits between the IR and the fetch/execute datapath; the datapath PC mux uses this block's pc_source encoding.

Parameters:
- TIMEOUT, 15: maximum cycles to wait for mem_ready in any wait state before FAULT.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26]; stable while the IR is held.
- funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- inst_req  out  1  instruction read request.
- data_req  out  1  data memory request.
- data_we  out  1  data request is a write.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC with the mux output.
- pc_source  out  2  00 jump target, 01 branch target, 10 jr (reg), 11 PC+4.
- branch_eq  out  1  executing beq.
- branch_ne  out  1  executing bne.
- jump  out  1  executing j/jal/jr.
- alu_src  out  1  ALU B from sign-extended immediate.
- alu_op  out  2  00 add, 01 sub, 10 by funct, 11 by opcode (immediate ops).
- reg_write  out  1  register-file write.
- reg_dst  out  1  destination is rd (R-type).
- mem_to_reg  out  1  write-back data from memory.
- link  out  1  jal: write PC+4 to r31.
- fault  out  1  sticky illegal-opcode or timeout flag.
- fault_code  out  2  01 timeout, 10 illegal opcode.
- inst_count  out  CNT_W  retired instructions.

Behaviour:
- Supported opcodes: R=000000 (jr when funct=001000), lw=100011, sw=101011, beq=000100, bne=000101, j=000010, jal=000011, addi=001000, slti=001010, andi=001100, ori=001101.
- Reset:
  - Reset high at an edge puts the FSM in IDLE and clears the timer, inst_count, fault and fault_code.
  - Reset aborts any operation in progress, including an outstanding memory request.
  - In IDLE every output is 0.
- Outputs are decoded from the state register, plus mem_ready and Zero where noted. Anything not listed for a state is 0.
- IDLE:
  - Always goes to FETCH.
- FETCH:
  - inst_req=1; pc_source=11.
  - When mem_ready=1: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
- DECODE:
  - No outputs asserted.
  - jr, j or jal goes to JUMP; beq or bne goes to BRANCH; other R-type, lw, sw and immediate ops go to EXEC.
  - Any other opcode goes to FAULT with fault_code=10.
- EXEC:
  - lw/sw: alu_src=1, alu_op=00.
  - R-type: alu_op=10.
  - Immediate ops: alu_src=1, alu_op=11.
  - Next state: lw goes to MEM_RD, sw goes to MEM_WR, all others go to WB.
- MEM_RD:
  - data_req=1, alu_src=1.
  - When mem_ready=1, go to WB.
- MEM_WR:
  - data_req=1, data_we=1, alu_src=1.
  - When mem_ready=1, go to FETCH and retire.
- WB:
  - reg_write=1; reg_dst=1 for R-type; mem_to_reg=1 for lw; alu_op and alu_src held as in EXEC.
  - Goes to FETCH and retires.
- BRANCH:
  - alu_op=01; branch_eq or branch_ne per op; pc_source=01.
  - pc_write = (beq & Zero) | (bne & ~Zero).
  - Goes to FETCH and retires in both cases.
  - The datapath computes the branch target from the already-incremented PC.
- JUMP:
  - jump=1, pc_write=1.
  - pc_source=00 for j/jal, 10 for jr.
  - jal also asserts link=1 and reg_write=1.
  - Goes to FETCH and retires.
- Retire: inst_count increments by 1 on each retiring transition and wraps modulo 2^CNT_W.
- Timer:
  - Counts cycles spent in FETCH, MEM_RD or MEM_WR while mem_ready=0.
  - Clears on entry to any state.
  - If it reaches TIMEOUT with mem_ready still 0, the next state is FAULT with fault_code=01.
  - If mem_ready=1 arrives in the same cycle as the timeout, mem_ready wins.
  - Timer width is clog2(TIMEOUT+1).
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- FAULT:
  - fault=1, fault_code held; all other outputs 0; inst_count frozen.
  - Leaves only on Reset.
- Latency with zero-wait memory:
  - R-type and immediate ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch and jump: 3 cycles.

Decomposition:
- Package multicycle_pkg holds:
  - opcode constants and the jr funct constant;
  - state encoding (IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, JUMP, FAULT);
  - pc_source encoding;
  - alu_op encoding;
  - fault_code values.
- One sub-module, mem_wait_timer:
  - inputs: Clock, Reset, clear, count_en;
  - output: expired.

Test Plan:
- Reset, then add (op=0, funct=100000) with mem_ready=1 always -> states IDLE, FETCH, DECODE, EXEC, WB, FETCH; reg_write=1 and reg_dst=1 in WB; inst_count=1.
- lw with mem_ready delayed 3 cycles in FETCH and 2 in MEM_RD -> ir_write and pc_write pulse once, on the ready cycle; mem_to_reg=1 in WB; lw takes 10 cycles total.
- beq with Zero=1, then beq with Zero=0 -> pc_write=1 with pc_source=01 for the first only; inst_count advances by 2.
- jal, then jr (funct=001000) -> jal: link=1, reg_write=1, pc_source=00; jr: pc_source=10, jump=1.
- Opcode 111111 -> FAULT after DECODE with fault=1, fault_code=10; FSM stays in FAULT for 20 cycles; Reset returns it to IDLE with fault=0.
- FETCH with mem_ready=0 for TIMEOUT cycles -> FAULT with fault_code=01.
- Repeat with mem_ready=1 on exactly the timeout cycle -> DECODE, no fault.
- Reset asserted mid MEM_WR -> IDLE on the next edge; data_req=0; inst_count=0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared encodings for the multi-cycle control FSM
package multicycle_pkg;

  // Opcodes (IR[31:26]) of the supported MIPS subset
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // R-type funct selecting jr
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM_RD = 4'd4,
    ST_MEM_WR = 4'd5,
    ST_WB     = 4'd6,
    ST_BRANCH = 4'd7,
    ST_JUMP   = 4'd8,
    ST_FAULT  = 4'd9
  } state_t;

  // PC mux select as seen by the datapath
  localparam logic [1:0] PC_SRC_JUMP   = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JR     = 2'b10;
  localparam logic [1:0] PC_SRC_PC4    = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

  // Instruction classes; every state decision works on these
  typedef enum logic [3:0] {
    CLS_R   = 4'd0,
    CLS_JR  = 4'd1,
    CLS_LW  = 4'd2,
    CLS_SW  = 4'd3,
    CLS_BEQ = 4'd4,
    CLS_BNE = 4'd5,
    CLS_J   = 4'd6,
    CLS_JAL = 4'd7,
    CLS_IMM = 4'd8,
    CLS_ILL = 4'd9
  } inst_class_t;

  function automatic inst_class_t classify(input logic [5:0] op, input logic [5:0] funct);
    inst_class_t cls;
    case (op)
      OP_RTYPE: cls = (funct == FUNCT_JR) ? CLS_JR : CLS_R;
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_BEQ:   cls = CLS_BEQ;
      OP_BNE:   cls = CLS_BNE;
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: cls = CLS_IMM;
      default:  cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating cycle counter for memory-ready waits
module mem_wait_timer
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_q;

  // Count non-ready wait cycles, holding at TIMEOUT until cleared
  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count_q <= '0;
    end else if (count_en && (count_q != TW'(TIMEOUT))) begin
      count_q <= count_q + TW'(1);
    end
  end

  assign expired = (count_q == TW'(TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the MIPS-subset datapath
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             inst_req,
  output logic             data_req,
  output logic             data_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             jump,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             link,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] inst_count
);

  state_t      state_q;
  state_t      state_d;
  inst_class_t cls;
  logic        wait_state;
  logic        timer_expired;
  logic        timeout_hit;
  logic        retire;
  logic [1:0]  fault_code_q;
  logic [CNT_W-1:0] count_q;

  assign cls         = classify(op, funct);
  assign wait_state  = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
  // A ready on the timeout cycle still completes the request
  assign timeout_hit = wait_state && timer_expired && !mem_ready;
  assign retire      = (state_q == ST_WB) || (state_q == ST_BRANCH) || (state_q == ST_JUMP) ||
                       ((state_q == ST_MEM_WR) && mem_ready);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (state_d != state_q),
    .count_en (wait_state && !mem_ready),
    .expired  (timer_expired)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)        state_d = ST_DECODE;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_DECODE: begin
        case (cls)
          CLS_JR, CLS_J, CLS_JAL:         state_d = ST_JUMP;
          CLS_BEQ, CLS_BNE:               state_d = ST_BRANCH;
          CLS_R, CLS_LW, CLS_SW, CLS_IMM: state_d = ST_EXEC;
          default:                        state_d = ST_FAULT;
        endcase
      end
      ST_EXEC: begin
        if (cls == CLS_LW)      state_d = ST_MEM_RD;
        else if (cls == CLS_SW) state_d = ST_MEM_WR;
        else                    state_d = ST_WB;
      end
      ST_MEM_RD: begin
        if (mem_ready)        state_d = ST_WB;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_MEM_WR: begin
        if (mem_ready)        state_d = ST_FETCH;
        else if (timeout_hit) state_d = ST_FAULT;
      end
      ST_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state, mem_ready and Zero
  always_comb begin
    inst_req   = 1'b0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PC_SRC_JUMP;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    jump       = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;
    fault      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        inst_req  = 1'b1;
        pc_source = PC_SRC_PC4;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_EXEC, ST_WB: begin
        if (cls == CLS_LW || cls == CLS_SW) begin
          alu_src = 1'b1;
          alu_op  = ALU_ADD;
        end else if (cls == CLS_IMM) begin
          alu_src = 1'b1;
          alu_op  = ALU_IMM;
        end else begin
          alu_op  = ALU_FUNCT;
        end
        if (state_q == ST_WB) begin
          reg_write  = 1'b1;
          reg_dst    = (cls == CLS_R);
          mem_to_reg = (cls == CLS_LW);
        end
      end
      ST_MEM_RD: begin
        data_req = 1'b1;
        alu_src  = 1'b1;
      end
      ST_MEM_WR: begin
        data_req = 1'b1;
        data_we  = 1'b1;
        alu_src  = 1'b1;
      end
      ST_BRANCH: begin
        alu_op    = ALU_SUB;
        pc_source = PC_SRC_BRANCH;
        branch_eq = (cls == CLS_BEQ);
        branch_ne = (cls == CLS_BNE);
        pc_write  = ((cls == CLS_BEQ) && Zero) || ((cls == CLS_BNE) && !Zero);
      end
      ST_JUMP: begin
        jump      = 1'b1;
        pc_write  = 1'b1;
        pc_source = (cls == CLS_JR) ? PC_SRC_JR : PC_SRC_JUMP;
        link      = (cls == CLS_JAL);
        reg_write = (cls == CLS_JAL);
      end
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  // Fault cause latch and retired-instruction counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fault_code_q <= FAULT_NONE;
      count_q      <= '0;
    end else begin
      if ((state_q != ST_FAULT) && (state_d == ST_FAULT)) begin
        fault_code_q <= timeout_hit ? FAULT_TIMEOUT : FAULT_ILLEGAL;
      end
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign fault_code = fault_code_q;
  assign inst_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        Zero;
  logic        mem_ready;
  logic        inst_req, data_req, data_we, ir_write, pc_write;
  logic [1:0]  pc_source;
  logic        branch_eq, branch_ne, jump, alu_src;
  logic [1:0]  alu_op;
  logic        reg_write, reg_dst, mem_to_reg, link, fault;
  logic [1:0]  fault_code;
  logic [31:0] inst_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc;
  int stuck;

  multicycle_ctrl #(.TIMEOUT(15), .CNT_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .op(op), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
    .inst_req(inst_req), .data_req(data_req), .data_we(data_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .jump(jump), .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .link(link), .fault(fault), .fault_code(fault_code),
    .inst_count(inst_count)
  );

  always #5 Clock = ~Clock;

  // All single-bit and select outputs packed, fault/fault_code in the low bits
  wire [19:0] outs = {inst_req, data_req, data_we, ir_write, pc_write, pc_source, branch_eq,
                      branch_ne, jump, alu_src, alu_op, reg_write, reg_dst, mem_to_reg, link,
                      fault, fault_code};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; op = 6'd0; funct = 6'd0; Zero = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    chk("reset_state", dut.state_q, ST_IDLE);
    chk("reset_outs", outs, 20'h0);
    chk("reset_count", inst_count, 0);

    // add with zero-wait memory
    Reset = 1'b0; op = OP_RTYPE; funct = 6'b100000; mem_ready = 1'b1;
    tick(); #1;
    chk("add_fetch_state", dut.state_q, ST_FETCH);
    chk("add_fetch_ctl", {inst_req, ir_write, pc_write, pc_source}, 5'b11111);
    tick();
    chk("add_decode_state", dut.state_q, ST_DECODE);
    chk("add_decode_outs", outs, 20'h0);
    tick();
    chk("add_exec_state", dut.state_q, ST_EXEC);
    chk("add_exec_alu", {alu_src, alu_op}, 3'b010);
    tick();
    chk("add_wb_state", dut.state_q, ST_WB);
    chk("add_wb_ctl", {reg_write, reg_dst, mem_to_reg}, 3'b110);
    tick();
    chk("add_back_fetch", dut.state_q, ST_FETCH);
    chk("add_count", inst_count, 1);

    // lw: 3 wait cycles in FETCH, 2 in MEM_RD -> 10 cycles
    start_cyc = cyc;
    op = OP_LW; mem_ready = 1'b0; #1;
    chk("lw_fetch_wait_ir", {ir_write, pc_write}, 2'b00);
    tick(); tick();
    chk("lw_fetch_wait_state", dut.state_q, ST_FETCH);
    chk("lw_fetch_wait_ir3", {ir_write, pc_write}, 2'b00);
    tick();
    mem_ready = 1'b1; #1;
    chk("lw_fetch_ready_ir", {ir_write, pc_write}, 2'b11);
    tick();
    mem_ready = 1'b0;
    chk("lw_decode_state", dut.state_q, ST_DECODE);
    tick();
    chk("lw_exec_alu", {alu_src, alu_op}, 3'b100);
    tick();
    chk("lw_memrd_ctl", {data_req, data_we, alu_src}, 3'b101);
    tick(); tick();
    chk("lw_memrd_hold", dut.state_q, ST_MEM_RD);
    mem_ready = 1'b1;
    tick();
    chk("lw_wb_ctl", {reg_write, reg_dst, mem_to_reg, alu_src}, 4'b1011);
    tick();
    chk("lw_latency", cyc - start_cyc, 10);
    chk("lw_count", inst_count, 2);

    // beq taken, beq not taken, bne taken
    op = OP_BEQ; Zero = 1'b1;
    tick(); tick();
    chk("beq1_state", dut.state_q, ST_BRANCH);
    chk("beq1_ctl", {pc_write, pc_source, branch_eq, branch_ne, alu_op}, 7'b1011001);
    tick(); Zero = 1'b0;
    tick(); tick(); #1;
    chk("beq0_ctl", {pc_write, pc_source, branch_eq, branch_ne}, 5'b00110);
    tick();
    chk("beq_count", inst_count, 4);
    op = OP_BNE;
    tick(); tick();
    chk("bne0_ctl", {pc_write, pc_source, branch_eq, branch_ne}, 5'b10101);
    tick();

    // jal then jr
    op = OP_JAL;
    tick(); tick();
    chk("jal_state", dut.state_q, ST_JUMP);
    chk("jal_ctl", {link, reg_write, pc_source, jump, pc_write}, 6'b110011);
    tick();
    op = OP_RTYPE; funct = FUNCT_JR;
    tick(); tick();
    chk("jr_ctl", {link, reg_write, pc_source, jump, pc_write}, 6'b001011);
    tick();
    chk("jump_count", inst_count, 7);

    // addi, then sw with zero-wait memory (4 cycles)
    op = OP_ADDI;
    tick(); tick();
    chk("addi_exec_alu", {alu_src, alu_op}, 3'b111);
    tick();
    chk("addi_wb_ctl", {reg_write, reg_dst, mem_to_reg}, 3'b100);
    tick();
    start_cyc = cyc;
    op = OP_SW;
    tick(); tick(); tick();
    chk("sw_memwr_ctl", {data_req, data_we, alu_src}, 3'b111);
    tick();
    chk("sw_latency_state", dut.state_q, ST_FETCH);
    chk("sw_latency", cyc - start_cyc, 4);
    chk("sw_count", inst_count, 9);

    // illegal opcode: sticky FAULT, count frozen
    op = 6'b111111;
    tick(); tick();
    chk("ill_state", dut.state_q, ST_FAULT);
    chk("ill_outs", outs, 20'h6);
    stuck = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      tick();
      if (dut.state_q == ST_FAULT && fault === 1'b1 && fault_code === FAULT_ILLEGAL) stuck++;
    end
    chk("ill_sticky_cycles", stuck, 20);
    chk("ill_count_frozen", inst_count, 9);
    Reset = 1'b1;
    tick();
    chk("ill_reset_state", dut.state_q, ST_IDLE);
    chk("ill_reset_outs", outs, 20'h0);
    chk("ill_reset_count", inst_count, 0);

    // FETCH starved: 15 waiting cycles, still 0 on the 16th -> timeout fault
    Reset = 1'b0; mem_ready = 1'b0; op = OP_RTYPE; funct = 6'b100000;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_last_cycle_state", dut.state_q, ST_FETCH);
    tick();
    chk("to_state", dut.state_q, ST_FAULT);
    chk("to_outs", outs, 20'h5);

    // ready on exactly the timeout cycle wins
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1; #1;
    chk("race_ir_write", ir_write, 1'b1);
    tick();
    chk("race_state", dut.state_q, ST_DECODE);
    chk("race_fault", {fault, fault_code}, 3'b000);
    tick(); tick(); tick();
    chk("race_count", inst_count, 1);

    // reset in the middle of a pending MEM_WR
    op = OP_SW;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("swr_state", dut.state_q, ST_MEM_WR);
    chk("swr_data_req", data_req, 1'b1);
    Reset = 1'b1;
    tick();
    chk("swr_reset_state", dut.state_q, ST_IDLE);
    chk("swr_reset_data_req", data_req, 1'b0);
    chk("swr_reset_count", inst_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
